// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 mapper: register select codes,
// reset value of the control register and the nametable mirroring codes.
package mmc1_pkg;

  typedef enum logic [1:0] {
    SEL_CTRL = 2'd0,
    SEL_CHR0 = 2'd1,
    SEL_CHR1 = 2'd2,
    SEL_PRG  = 2'd3
  } reg_sel_e;

  localparam logic [4:0] CTRL_RST = 5'h0C;

  // Mirroring codes understood by the nametable logic; 1A/1B are one-screen.
  localparam logic [2:0] MIRR_HOR = 3'd0;
  localparam logic [2:0] MIRR_VER = 3'd1;
  localparam logic [2:0] MIRR_4   = 3'd2;
  localparam logic [2:0] MIRR_1A  = 3'd3;
  localparam logic [2:0] MIRR_1B  = 3'd4;

  function automatic logic [2:0] mirr_decode(input logic [1:0] m);
    logic [2:0] r;
    case (m)
      2'd0:    r = MIRR_1A;
      2'd1:    r = MIRR_1B;
      2'd2:    r = MIRR_VER;
      default: r = MIRR_HOR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mmc1_if.sv
// Cartridge-side bus bundle for the MMC1 mapper: CPU/PPU buses, PRG/CHR
// memory ports, iNES header and mirroring/irq outputs.
interface mmc1_if;
  logic [15:0]  memaddr;
  logic [7:0]   memwdata;
  logic         memwr;
  logic         prgreq;
  logic [7:0]   prgrdata;
  logic         prgack;

  logic [13:0]  vmemaddr;
  logic [7:0]   vmemwdata;
  logic         vmemwr;
  logic         chrreq;
  logic [7:0]   chrrdata;
  logic         chrack;

  logic [20:0]  promaddr;
  logic         promreq;
  logic [7:0]   promdata;
  logic         promack;

  logic [20:0]  cromaddr;
  logic         cromreq;
  logic [7:0]   cromdata;
  logic         cromack;

  logic [12:0]  chrramaddr;
  logic [7:0]   chrramwdata;
  logic         chrramwr;
  logic         chrramreq;
  logic [7:0]   chrramrdata;
  logic         chrramack;

  logic [127:0] header;
  logic [2:0]   mirr;
  logic         irq;

  modport slave (
    input  memaddr, memwdata, memwr, prgreq,
    output prgrdata, prgack,
    input  vmemaddr, vmemwdata, vmemwr, chrreq,
    output chrrdata, chrack,
    output promaddr, promreq,
    input  promdata, promack,
    output cromaddr, cromreq,
    input  cromdata, cromack,
    output chrramaddr, chrramwdata, chrramwr, chrramreq,
    input  chrramrdata, chrramack,
    input  header,
    output mirr, irq
  );

  modport master (
    output memaddr, memwdata, memwr, prgreq,
    input  prgrdata, prgack,
    output vmemaddr, vmemwdata, vmemwr, chrreq,
    input  chrrdata, chrack,
    input  promaddr, promreq,
    output promdata, promack,
    input  cromaddr, cromreq,
    output cromdata, cromack,
    input  chrramaddr, chrramwdata, chrramwr, chrramreq,
    output chrramrdata, chrramack,
    output header,
    input  mirr, irq
  );
endinterface

// File: rtl/mmc1_shift.sv
// MMC1 serial loader: write-edge detect, 5-bit LSB-first shift register and
// write count, producing a one-cycle load strobe with target select and value.
module mmc1_shift
  import mmc1_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     memwr_i,
  input  logic     addr15_i,
  input  logic [1:0] addrsel_i,
  input  logic     wbit7_i,
  input  logic     wbit0_i,
  output logic     load_o,
  output logic     clr_o,
  output reg_sel_e sel_o,
  output logic [4:0] val_o
);

  logic       memwr_q;
  logic [4:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_evt;

  // A held memwr only counts on its first cycle.
  assign wr_evt = memwr_i & ~memwr_q & addr15_i;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load_o  = 1'b0;
    clr_o   = 1'b0;
    if (wr_evt) begin
      if (wbit7_i) begin
        shift_d = '0;
        cnt_d   = '0;
        clr_o   = 1'b1;
      end else if (cnt_q == 3'd4) begin
        shift_d = '0;
        cnt_d   = '0;
        load_o  = 1'b1;
      end else begin
        shift_d = {wbit0_i, shift_q[4:1]};
        cnt_d   = cnt_q + 3'd1;
      end
    end
  end

  assign sel_o = reg_sel_e'(addrsel_i);
  assign val_o = {wbit0_i, shift_q[4:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwr_q <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      memwr_q <= memwr_i;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mmc1.sv
// MMC1 (SxROM) mapper top: bank registers, PRG/CHR address mapping, CHR
// ROM/RAM steering and runtime nametable mirroring.
module mmc1
  import mmc1_pkg::*;
#(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 5
) (
  input logic  clk,
  input logic  reset,
  mmc1_if.slave bus
);

  logic       load, clr;
  reg_sel_e   sel;
  logic [4:0] val;

  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  mmc1_shift u_shift (
    .clk       (clk),
    .reset     (reset),
    .memwr_i   (bus.memwr),
    .addr15_i  (bus.memaddr[15]),
    .addrsel_i (bus.memaddr[14:13]),
    .wbit7_i   (bus.memwdata[7]),
    .wbit0_i   (bus.memwdata[0]),
    .load_o    (load),
    .clr_o     (clr),
    .sel_o     (sel),
    .val_o     (val)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    prg_d  = prg_q;
    if (clr) ctrl_d[3:2] = 2'b11;
    if (load) begin
      case (sel)
        SEL_CTRL: ctrl_d = val;
        SEL_CHR0: chr0_d = val;
        SEL_CHR1: chr1_d = val;
        default:  prg_d  = val;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= CTRL_RST;
      chr0_q <= '0;
      chr1_q <= '0;
      prg_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
    end
  end

  // PRG mapping; the header bank count is a power of two so count-1 is a mask.
  logic [PRG_BANK_W-1:0] prg_mask, prg_sel, prg_bank;
  logic                  a14;

  assign prg_mask = PRG_BANK_W'(bus.header[39:32] - 8'd1);
  assign prg_sel  = prg_q[PRG_BANK_W-1:0];
  assign a14      = bus.memaddr[14];

  always_comb begin
    case (ctrl_q[3:2])
      2'b10:   prg_bank = a14 ? prg_sel : '0;
      2'b11:   prg_bank = a14 ? prg_mask : prg_sel;
      default: prg_bank = {prg_sel[PRG_BANK_W-1:1], a14};
    endcase
  end

  assign bus.promaddr = 21'({prg_bank & prg_mask, bus.memaddr[13:0]});
  assign bus.promreq  = bus.prgreq;
  assign bus.prgack   = bus.promack;
  assign bus.prgrdata = bus.promdata;

  // CHR mapping in 4 KB units; 8 KB mode ignores chr0 bit 0.
  logic [CHR_BANK_W-1:0] chr_bank;
  logic                  v12, chr_ram;

  assign v12     = bus.vmemaddr[12];
  assign chr_ram = (bus.header[47:40] == 8'd0);

  always_comb begin
    if (ctrl_q[4]) chr_bank = v12 ? chr1_q[CHR_BANK_W-1:0] : chr0_q[CHR_BANK_W-1:0];
    else           chr_bank = {chr0_q[CHR_BANK_W-1:1], v12};
  end

  assign bus.cromaddr    = 21'({chr_bank, bus.vmemaddr[11:0]});
  assign bus.chrramaddr  = {chr_bank[0], bus.vmemaddr[11:0]};
  assign bus.cromreq     = bus.chrreq & ~chr_ram;
  assign bus.chrramreq   = bus.chrreq & chr_ram;
  assign bus.chrramwr    = bus.vmemwr;
  assign bus.chrramwdata = bus.vmemwdata;
  assign bus.chrack      = chr_ram ? bus.chrramack : bus.cromack;
  assign bus.chrrdata    = chr_ram ? bus.chrramrdata : bus.cromdata;

  assign bus.mirr = mirr_decode(ctrl_q[1:0]);
  assign bus.irq  = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.memwdata[6:1], bus.header[127:48], bus.header[31:0],
                         bus.vmemaddr[13], prg_q[4]};

endmodule

// File: tb/tb_mmc1.sv
// Self-checking bench for mmc1: directed scenarios plus randomized write/read
// traffic compared against a bank-arithmetic reference model.
module tb_mmc1;
  import mmc1_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mmc1_if bus();

  mmc1 #(.PRG_BANK_W(4), .CHR_BANK_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state: plain integers, bits collected in write order.
  int m_ctrl, m_chr0, m_chr1, m_prg, m_cnt;
  bit m_bits[5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_cnt = 0;
  endtask

  task automatic mdl_write(input logic [15:0] a, input logic [7:0] d);
    int v;
    if (!a[15]) return;
    if (d[7]) begin
      m_cnt = 0;
      m_ctrl = m_ctrl | 12;
      return;
    end
    m_bits[m_cnt] = d[0];
    if (m_cnt == 4) begin
      v = 0;
      for (int i = 0; i < 5; i++) v += int'(m_bits[i]) << i;
      case (a[14:13])
        2'd0: m_ctrl = v;
        2'd1: m_chr0 = v;
        2'd2: m_chr1 = v;
        default: m_prg = v;
      endcase
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [2:0] exp_mirr();
    case (m_ctrl % 4)
      0: return MIRR_1A;
      1: return MIRR_1B;
      2: return MIRR_VER;
      default: return MIRR_HOR;
    endcase
  endfunction

  // Compare every output against the model for the current bus inputs.
  task automatic check_map();
    int a, v, mode, mask, bank, bk4, ramsel;
    a    = int'(bus.memaddr);
    v    = int'(bus.vmemaddr);
    mode = (m_ctrl / 4) % 4;
    mask = (int'(bus.header[39:32]) - 1) & 15;
    if (mode < 2)       bank = (m_prg & 14) | ((a / 16384) % 2);
    else if (mode == 2) bank = ((a / 16384) % 2) ? (m_prg & 15) : 0;
    else                bank = ((a / 16384) % 2) ? 15 : (m_prg & 15);
    bank = bank & mask;
    check("promaddr", 32'(bus.promaddr), 32'(bank * 16384 + a % 16384));
    check("promreq", 32'(bus.promreq), 32'(bus.prgreq));
    check("prgack", 32'(bus.prgack), 32'(bus.promack));
    check("prgrdata", 32'(bus.prgrdata), 32'(bus.promdata));
    if (m_ctrl & 16) bk4 = ((v / 4096) % 2) ? m_chr1 : m_chr0;
    else             bk4 = (m_chr0 & 30) | ((v / 4096) % 2);
    ramsel = (bus.header[47:40] == 8'd0) ? 1 : 0;
    if (ramsel != 0) begin
      check("chrramaddr", 32'(bus.chrramaddr), 32'((bk4 % 2) * 4096 + v % 4096));
      check("cromreq_ram", 32'(bus.cromreq), 32'd0);
      check("chrramreq", 32'(bus.chrramreq), 32'(bus.chrreq));
      check("chrack_ram", 32'(bus.chrack), 32'(bus.chrramack));
      check("chrrdata_ram", 32'(bus.chrrdata), 32'(bus.chrramrdata));
    end else begin
      check("cromaddr", 32'(bus.cromaddr), 32'(bk4 * 4096 + v % 4096));
      check("cromreq", 32'(bus.cromreq), 32'(bus.chrreq));
      check("chrramreq_rom", 32'(bus.chrramreq), 32'd0);
      check("chrack_rom", 32'(bus.chrack), 32'(bus.cromack));
      check("chrrdata_rom", 32'(bus.chrrdata), 32'(bus.cromdata));
    end
    check("chrramwr", 32'(bus.chrramwr), 32'(bus.vmemwr));
    check("chrramwdata", 32'(bus.chrramwdata), 32'(bus.vmemwdata));
    check("mirr", 32'(bus.mirr), 32'(exp_mirr()));
    check("irq", 32'(bus.irq), 32'd0);
  endtask

  task automatic rnd_side();
    bus.promdata    = 8'($urandom);
    bus.promack     = 1'($urandom);
    bus.cromdata    = 8'($urandom);
    bus.cromack     = 1'($urandom);
    bus.chrramrdata = 8'($urandom);
    bus.chrramack   = 1'($urandom);
    bus.vmemwdata   = 8'($urandom);
    bus.vmemwr      = 1'($urandom);
  endtask

  task automatic rd(input logic [15:0] a, input logic [13:0] v, input logic req);
    @(negedge clk);
    bus.memaddr  = a;
    bus.vmemaddr = v;
    bus.prgreq   = req;
    bus.chrreq   = req;
    rnd_side();
    #1;
    check_map();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    bus.memaddr  = a;
    bus.memwdata = d;
    bus.memwr    = 1'b1;
    mdl_write(a, d);
    repeat (hold) @(negedge clk);
    bus.memwr = 1'b0;
  endtask

  task automatic wr_val(input logic [15:0] a, input int val);
    for (int i = 0; i < 5; i++) do_write(a, 8'((val >> i) & 1), 1);
  endtask

  task automatic set_header(input int nprg, input int nchr);
    bus.header = '0;
    bus.header[39:32] = 8'(nprg);
    bus.header[47:40] = 8'(nchr);
  endtask

  initial begin
    int op;
    logic [15:0] a;
    logic [7:0]  d;
    bus.memaddr = 16'h0; bus.memwdata = 8'h0; bus.memwr = 1'b0; bus.prgreq = 1'b0;
    bus.vmemaddr = 14'h0; bus.chrreq = 1'b0;
    rnd_side();
    set_header(8, 16);
    reset = 1'b1;
    mdl_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    rd(16'hC000, 14'h0, 1'b1);
    check("rst_c000", 32'(bus.promaddr), 32'h1C000);
    rd(16'h8000, 14'h0, 1'b1);
    check("rst_8000", 32'(bus.promaddr), 32'h00000);
    check("rst_mirr", 32'(bus.mirr), 32'(MIRR_1A));

    // Control = 0x12: vertical mirroring, 32 KB PRG mode
    wr_val(16'h8000, 5'h12);
    rd(16'hA000, 14'h0, 1'b1);
    check("ctl12_mirr", 32'(bus.mirr), 32'(MIRR_VER));
    check("ctl12_prom", 32'(bus.promaddr), 32'h02000);

    // Partial sequence aborted by a bit-7 write
    for (int i = 0; i < 3; i++) do_write(16'hE000, 8'h01, 1);
    do_write(16'h8000, 8'h80, 1);
    wr_val(16'hE000, 5'h03);
    rd(16'h8000, 14'h0, 1'b1);
    check("noleak_prom", 32'(bus.promaddr), 32'h0C000);

    // Fifth bit held for four cycles loads once
    for (int i = 0; i < 4; i++) do_write(16'hE000, 8'((5'h06 >> i) & 1), 1);
    do_write(16'hE000, 8'h00, 4);
    rd(16'h8000, 14'h0, 1'b1);
    check("hold_prom", 32'(bus.promaddr), 32'h18000);
    wr_val(16'hA000, 5'h09);
    rd(16'h8000, 14'h0000, 1'b1);
    check("hold_next_prom", 32'(bus.promaddr), 32'h18000);

    // CHR 4 KB mode
    wr_val(16'h8000, 5'h1F);
    wr_val(16'hA000, 5'h03);
    wr_val(16'hC000, 5'h05);
    rd(16'h8000, 14'h0010, 1'b1);
    check("chr4k_lo", 32'(bus.cromaddr), 32'h3010);
    rd(16'h8000, 14'h1010, 1'b1);
    check("chr4k_hi", 32'(bus.cromaddr), 32'h5010);
    set_header(8, 0);
    rd(16'h8000, 14'h1010, 1'b1);
    check("chrram_addr", 32'(bus.chrramaddr), 32'h1010);
    check("chrram_cromreq", 32'(bus.cromreq), 32'd0);

    // Asynchronous reset mid-sequence
    set_header(8, 16);
    do_write(16'h8000, 8'h01, 1);
    do_write(16'h8000, 8'h00, 1);
    @(negedge clk);
    bus.memaddr = 16'hC000;
    #2 reset = 1'b1;
    #1;
    mdl_reset();
    check("arst_mirr", 32'(bus.mirr), 32'(MIRR_1A));
    check("arst_c000", 32'(bus.promaddr), 32'h1C000);
    @(negedge clk);
    reset = 1'b0;
    wr_val(16'h8000, 5'h0E);
    rd(16'h8000, 14'h0, 1'b1);
    check("arst_reload_mirr", 32'(bus.mirr), 32'(MIRR_VER));

    // memwr still high when reset releases counts as a write
    set_header(16, 16);
    @(negedge clk);
    reset = 1'b1;
    bus.memaddr = 16'hE000; bus.memwdata = 8'h01; bus.memwr = 1'b1;
    mdl_reset();
    @(negedge clk);
    reset = 1'b0;
    mdl_write(16'hE000, 8'h01);
    @(negedge clk);
    bus.memwr = 1'b0;
    do_write(16'hE000, 8'h00, 1);
    do_write(16'hE000, 8'h01, 1);
    do_write(16'hE000, 8'h00, 1);
    do_write(16'hE000, 8'h00, 1);
    rd(16'h8000, 14'h0, 1'b1);
    check("relwr_prom", 32'(bus.promaddr), 32'h14000);

    // Randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      set_header(2 << $urandom_range(0, 3), ($urandom_range(0, 1) != 0) ? 16 : 0);
      for (int n = 0; n < 120; n++) begin
        op = int'($urandom_range(0, 9));
        if (op < 6) begin
          a = 16'($urandom);
          if ($urandom_range(0, 7) != 0) a[15] = 1'b1;
          d = 8'($urandom);
          d[7] = ($urandom_range(0, 9) == 0);
          do_write(a, d, int'($urandom_range(1, 3)));
        end else begin
          rd(16'($urandom), 14'($urandom), 1'($urandom));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
